// File: rtl/shift_unit_seq_pkg.sv
// rtl/shift_unit_seq_pkg.sv - shift mode and FSM state encodings shared by the shifter files
package shift_unit_seq_pkg;

   typedef enum logic [1:0] {
      MODE_SLL  = 2'd0,
      MODE_SRL  = 2'd1,
      MODE_SRA  = 2'd2,
      MODE_ROTR = 2'd3
   } shift_mode_t;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } shift_state_t;

endpackage

// File: rtl/shift_unit_seq_if.sv
// rtl/shift_unit_seq_if.sv - request/result bundle between control unit and sequential shifter
interface shift_unit_seq_if #(
   parameter int DATA_W = 32
);
   localparam int SHAMT_W = $clog2(DATA_W);

   logic               start_i;
   logic [1:0]         mode_i;
   logic [DATA_W-1:0]  data_i;
   logic [SHAMT_W-1:0] shamt_i;
   logic               busy_o;
   logic               done_o;
   logic [DATA_W-1:0]  data_o;

   modport master (
      output start_i, mode_i, data_i, shamt_i,
      input  busy_o, done_o, data_o
   );

   modport slave (
      input  start_i, mode_i, data_i, shamt_i,
      output busy_o, done_o, data_o
   );
endinterface

// File: rtl/shift_step.sv
// rtl/shift_step.sv - one combinational shift slice of up to STEP bits
module shift_step
   import shift_unit_seq_pkg::*;
#(
   parameter int  DATA_W = 32,
   parameter int  STEP   = 4,
   localparam int K_W    = $clog2(STEP + 1)
) (
   input  logic [DATA_W-1:0] acc,
   input  logic [K_W-1:0]    k,
   input  shift_mode_t       mode,
   output logic [DATA_W-1:0] acc_next
);

   always_comb begin
      case (mode)
         MODE_SLL: acc_next = acc << k;
         MODE_SRL: acc_next = acc >> k;
         // acc MSB never changes under SRA, so it carries the original sign every step
         MODE_SRA: acc_next = DATA_W'($signed(acc) >>> k);
         default:  acc_next = (acc >> k) | (acc << (DATA_W - int'(k)));
      endcase
   end

endmodule

// File: rtl/shift_unit_seq.sv
// rtl/shift_unit_seq.sv - multi-cycle SLL/SRL/SRA/ROTR shifter, STEP bits per clock
module shift_unit_seq
   import shift_unit_seq_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int STEP    = 4,
   parameter int SHAMT_W = $clog2(DATA_W)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   shift_unit_seq_if.slave bus
);

   localparam int               K_W    = $clog2(STEP + 1);
   localparam int               CNT_W  = SHAMT_W + 1;
   localparam logic [CNT_W-1:0] STEP_C = CNT_W'(STEP);

   shift_state_t       state, state_next;
   shift_mode_t        mode_q;
   logic [DATA_W-1:0]  acc, acc_step;
   logic [SHAMT_W-1:0] rem;
   logic [CNT_W-1:0]   rem_ext, k_ext;
   logic [K_W-1:0]     k;
   logic               last_step;
   logic               accept;

   // one extra bit so STEP=DATA_W still compares cleanly against rem
   assign rem_ext   = {1'b0, rem};
   assign k_ext     = (rem_ext > STEP_C) ? STEP_C : rem_ext;
   assign k         = K_W'(k_ext);
   assign last_step = (rem_ext <= STEP_C);
   assign accept    = (state == S_IDLE) && bus.start_i;

   shift_step #(
      .DATA_W (DATA_W),
      .STEP   (STEP)
   ) u_step (
      .acc      (acc),
      .k        (k),
      .mode     (mode_q),
      .acc_next (acc_step)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_i) state <= S_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (bus.start_i) state_next = (bus.shamt_i == '0) ? S_DONE : S_SHIFT;
         S_SHIFT: if (last_step) state_next = S_DONE;
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_comb begin
      bus.busy_o = (state != S_IDLE);
      bus.done_o = (state == S_DONE);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         acc    <= '0;
         rem    <= '0;
         mode_q <= MODE_SLL;
      end else if (accept) begin
         acc    <= bus.data_i;
         rem    <= bus.shamt_i;
         mode_q <= shift_mode_t'(bus.mode_i);
      end else if (state == S_SHIFT) begin
         acc    <= acc_step;
         rem    <= SHAMT_W'(rem_ext - k_ext);
      end
   end

   assign bus.data_o = acc;

endmodule

// File: tb/tb_shift_unit_seq.sv
// tb/tb_shift_unit_seq.sv - self-checking bench for shift_unit_seq (DATA_W=32, STEP=4)
module tb_shift_unit_seq;

   logic clk_i = 1'b0;
   logic rst_i = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk_i = ~clk_i;

   shift_unit_seq_if #(.DATA_W(32)) bus ();

   shift_unit_seq #(.DATA_W(32), .STEP(4)) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus)
   );

   typedef struct {
      logic [1:0]  mode;
      logic [31:0] data;
      logic [4:0]  shamt;
      logic [31:0] exp_d;
      int          exp_lat;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_shift(input logic [1:0] m, input logic [31:0] d, input int s);
      logic [63:0] dd;
      dd = {d, d};
      case (m)
         2'd0:    return d << s;
         2'd1:    return d >> s;
         2'd2:    return 32'($signed(d) >>> s);
         default: return dd[s +: 32];
      endcase
   endfunction

   function automatic int ref_lat(input int s);
      return (s == 0) ? 1 : (s + 3) / 4 + 1;
   endfunction

   // caller is in cycle c+1 with start already dropped
   task automatic wait_done(input logic [31:0] exp_d, input int exp_lat, input string nm);
      int lat;
      chk({nm, " busy"}, 32'(bus.busy_o), 32'd1);
      lat = 1;
      while (!bus.done_o && lat < 64) begin
         @(posedge clk_i); #1;
         lat++;
      end
      if (!bus.done_o) lat = 0;
      chk({nm, " lat"}, 32'(lat), 32'(exp_lat));
      chk({nm, " data"}, bus.data_o, exp_d);
      @(posedge clk_i); #1;
      chk({nm, " done1"}, 32'(bus.done_o), 32'd0);
      chk({nm, " idle"}, 32'(bus.busy_o), 32'd0);
      repeat (2) @(posedge clk_i);
      #1;
      chk({nm, " hold"}, bus.data_o, exp_d);
   endtask

   task automatic run_op(input logic [1:0] m, input logic [31:0] d, input logic [4:0] s,
                         input logic [31:0] exp_d, input int exp_lat, input string nm);
      bus.start_i = 1'b1;
      bus.mode_i  = m;
      bus.data_i  = d;
      bus.shamt_i = s;
      @(posedge clk_i); #1;
      bus.start_i = 1'b0;
      bus.mode_i  = 2'($urandom);
      bus.data_i  = $urandom;
      bus.shamt_i = 5'($urandom);
      wait_done(exp_d, exp_lat, nm);
   endtask

   initial begin
      int ndone;
      int done_cyc;
      bit seen;

      vecs[0] = '{2'd0, 32'h0000_0001, 5'd2,  32'h0000_0004, 2};
      vecs[1] = '{2'd2, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 9};
      vecs[2] = '{2'd1, 32'h8000_0000, 5'd31, 32'h0000_0001, 9};
      vecs[3] = '{2'd3, 32'h1234_5678, 5'd8,  32'h7812_3456, 3};
      vecs[4] = '{2'd3, 32'h0000_0001, 5'd3,  32'h2000_0000, 2};
      vecs[5] = '{2'd1, 32'hF000_0000, 5'd0,  32'hF000_0000, 1};
      vecs[6] = '{2'd0, 32'h0000_0001, 5'd31, 32'h8000_0000, 9};
      vecs[7] = '{2'd2, 32'h7000_0000, 5'd4,  32'h0700_0000, 2};

      bus.start_i = 1'b0;
      bus.mode_i  = 2'd0;
      bus.data_i  = '0;
      bus.shamt_i = '0;
      repeat (3) @(posedge clk_i);
      #1;
      chk("rst busy", 32'(bus.busy_o), 32'd0);
      chk("rst done", 32'(bus.done_o), 32'd0);
      chk("rst data", bus.data_o, 32'd0);
      rst_i = 1'b1;
      @(posedge clk_i); #1;

      for (int i = 0; i < 8; i++)
         run_op(vecs[i].mode, vecs[i].data, vecs[i].shamt, vecs[i].exp_d, vecs[i].exp_lat,
                $sformatf("vec%0d", i));

      // starts during SHIFT and during DONE are dropped; start right after DONE is taken
      bus.start_i = 1'b1; bus.mode_i = 2'd0; bus.data_i = 32'h0000_0003; bus.shamt_i = 5'd20;
      @(posedge clk_i); #1;
      bus.start_i = 1'b0;
      ndone = 0;
      done_cyc = -1;
      for (int cyc = 1; cyc <= 7; cyc++) begin
         bus.start_i = (cyc == 2 || cyc == 6 || cyc == 7);
         if (cyc == 2 || cyc == 6) begin
            bus.mode_i = 2'd1; bus.data_i = 32'hFFFF_FFFF; bus.shamt_i = 5'd1;
         end
         if (cyc == 7) begin
            bus.mode_i = 2'd1; bus.data_i = 32'h0000_0080; bus.shamt_i = 5'd4;
         end
         if (bus.done_o) begin
            ndone++;
            done_cyc = cyc;
            chk("ign data", bus.data_o, 32'h0030_0000);
         end
         if (cyc < 7) @(posedge clk_i);
         if (cyc < 7) #1;
      end
      @(posedge clk_i); #1;
      bus.start_i = 1'b0;
      chk("ign ndone", 32'(ndone), 32'd1);
      chk("ign cyc", 32'(done_cyc), 32'd6);
      wait_done(32'h0000_0008, 2, "after_ign");

      // reset in the middle of a long SRA
      bus.start_i = 1'b1; bus.mode_i = 2'd2; bus.data_i = 32'h8000_0000; bus.shamt_i = 5'd31;
      @(posedge clk_i); #1;
      bus.start_i = 1'b0;
      seen = 1'b0;
      for (int cyc = 1; cyc < 4; cyc++) begin
         if (bus.done_o) seen = 1'b1;
         @(posedge clk_i); #1;
      end
      rst_i = 1'b0;
      @(posedge clk_i); #1;
      rst_i = 1'b1;
      chk("abort busy", 32'(bus.busy_o), 32'd0);
      chk("abort data", bus.data_o, 32'd0);
      for (int cyc = 0; cyc < 15; cyc++) begin
         if (bus.done_o) seen = 1'b1;
         @(posedge clk_i); #1;
      end
      chk("abort nodone", 32'(seen), 32'd0);
      run_op(2'd3, 32'h1234_5678, 5'd8, 32'h7812_3456, 3, "post_rst");

      for (int i = 0; i < 40; i++) begin
         logic [1:0]  m;
         logic [31:0] d;
         int          s;
         m = 2'($urandom_range(0, 3));
         d = $urandom;
         s = $urandom_range(0, 31);
         run_op(m, d, 5'(s), ref_shift(m, d, s), ref_lat(s), $sformatf("rnd%0d", i));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
